// File: rtl/alu_ctrl_mc_if.sv
// Bus between the ID/EX register and the EX-stage ALU control / mul-div sequencer.
// The master drives instruction fields; the slave (alu_ctrl_mc) returns decode and sequencing.
interface alu_ctrl_mc_if #(
  parameter int unsigned CTRL_WIDTH = 5
);
  logic                  valid_i;
  logic                  flush_i;
  logic [5:0]            funct_i;
  logic [3:0]            ALUOp_i;
  logic [CTRL_WIDTH-1:0] ALUCtrl_o;
  logic                  Sign_extend_o;
  logic [1:0]            Mux_ALU_src1_o;
  logic                  Jump_R_o;
  logic                  illegal_o;
  logic                  mul_start_o;
  logic [1:0]            mul_op_o;
  logic                  stall_o;
  logic                  hilo_we_o;

  modport master (
    output valid_i, flush_i, funct_i, ALUOp_i,
    input  ALUCtrl_o, Sign_extend_o, Mux_ALU_src1_o, Jump_R_o, illegal_o,
    input  mul_start_o, mul_op_o, stall_o, hilo_we_o
  );

  modport slave (
    input  valid_i, flush_i, funct_i, ALUOp_i,
    output ALUCtrl_o, Sign_extend_o, Mux_ALU_src1_o, Jump_R_o, illegal_o,
    output mul_start_o, mul_op_o, stall_o, hilo_we_o
  );
endinterface

// File: rtl/alu_ctrl_mc.sv
// EX-stage ALU control decoder with a multi-cycle MULT/MULTU/DIV/DIVU sequencer.
// Define ALU_CTRL_DIV_EN to decode DIV/DIVU and build the DIV_CYCLES latency path.
module alu_ctrl_mc #(
  parameter int unsigned CTRL_WIDTH = 5,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_ctrl_mc_if.slave    bus
);

  localparam logic [CTRL_WIDTH-1:0] CodeAnd   = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] CodeOr    = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CodeLw    = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] CodeSw    = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] CodeAddu  = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] CodeSubu  = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] CodeSlt   = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] CodeBlez  = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] CodeSra   = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] CodeSrav  = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] CodeLui   = CTRL_WIDTH'(10);
  localparam logic [CTRL_WIDTH-1:0] CodeSltu  = CTRL_WIDTH'(11);
  localparam logic [CTRL_WIDTH-1:0] CodeSll   = CTRL_WIDTH'(12);
  localparam logic [CTRL_WIDTH-1:0] CodeMult  = CTRL_WIDTH'(13);
  localparam logic [CTRL_WIDTH-1:0] CodeBgtz  = CTRL_WIDTH'(14);
  localparam logic [CTRL_WIDTH-1:0] CodeMultu = CTRL_WIDTH'(15);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CTRL_WIDTH-1:0] CodeDiv   = CTRL_WIDTH'(16);
  localparam logic [CTRL_WIDTH-1:0] CodeDivu  = CTRL_WIDTH'(17);
`endif
  localparam logic [CTRL_WIDTH-1:0] CodeJr    = CTRL_WIDTH'(18);

  localparam int unsigned CntMax = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
`ifdef ALU_CTRL_DIV_EN
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              mul_start_q;
  logic [1:0]        mul_op_q;
  logic              hilo_we_q;

  logic [CTRL_WIDTH-1:0] alu_ctrl;
  logic                  sext;
  logic [1:0]            src1;
  logic                  jump_r;
  logic                  unknown;
  logic                  muldiv;
  logic                  accept;
  logic [CntW-1:0]       cnt_load;

  always_comb begin
    alu_ctrl = CodeAnd;
    sext     = 1'b0;
    src1     = 2'd0;
    jump_r   = 1'b0;
    unknown  = 1'b0;
    muldiv   = 1'b0;
    case (bus.ALUOp_i)
      4'd0: begin
        case (bus.funct_i)
          6'b100001: alu_ctrl = CodeAddu;
          6'b100011: alu_ctrl = CodeSubu;
          6'b100100: alu_ctrl = CodeAnd;
          6'b100101: alu_ctrl = CodeOr;
          6'b101010: alu_ctrl = CodeSlt;
          6'b000011: begin alu_ctrl = CodeSra;  src1   = 2'd1; end
          6'b000111: alu_ctrl = CodeSrav;
          6'b000000: begin alu_ctrl = CodeSll;  src1   = 2'd1; end
          6'b001000: begin alu_ctrl = CodeJr;   jump_r = 1'b1; end
          6'b011000: begin alu_ctrl = CodeMult;  muldiv = 1'b1; end
          6'b011001: begin alu_ctrl = CodeMultu; muldiv = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
          6'b011010: begin alu_ctrl = CodeDiv;   muldiv = 1'b1; end
          6'b011011: begin alu_ctrl = CodeDivu;  muldiv = 1'b1; end
`endif
          default:   unknown = 1'b1;
        endcase
      end
      4'd1:    begin alu_ctrl = CodeAddu; sext = 1'b1; end
      4'd2:    alu_ctrl = CodeSltu;
      4'd3:    begin alu_ctrl = CodeSubu; sext = 1'b1; end
      4'd4:    alu_ctrl = CodeLui;
      4'd5:    alu_ctrl = CodeOr;
      4'd6:    begin alu_ctrl = CodeSubu; sext = 1'b1; end
      4'd7:    begin alu_ctrl = CodeLw;   sext = 1'b1; end
      4'd8:    begin alu_ctrl = CodeSw;   sext = 1'b1; end
      4'd9:    begin alu_ctrl = CodeBlez; sext = 1'b1; end
      4'd10:   begin alu_ctrl = CodeBgtz; sext = 1'b1; end
      4'd11:   alu_ctrl = CodeAddu;
      4'd12:   begin alu_ctrl = CodeAddu; sext = 1'b1; end
      4'd13:   begin alu_ctrl = CodeAddu; sext = 1'b1; end
      default: unknown = 1'b1;
    endcase
  end

  assign accept = (state_q == StIdle) && bus.valid_i && !bus.flush_i && muldiv;

`ifdef ALU_CTRL_DIV_EN
  assign cnt_load = bus.funct_i[1] ? DivLoad : MulLoad;
`else
  assign cnt_load = MulLoad;
`endif

  // RUN lasts exactly latency cycles: count is loaded with latency-1 and exits at zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      mul_op_q    <= 2'd0;
      hilo_we_q   <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      hilo_we_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StRun;
            mul_start_q <= 1'b1;
            mul_op_q    <= bus.funct_i[1:0];
            cnt_q       <= cnt_load;
          end
        end
        StRun: begin
          if (bus.flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q   <= StDone;
            hilo_we_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ALUCtrl_o      = alu_ctrl;
  assign bus.Sign_extend_o  = sext;
  assign bus.Mux_ALU_src1_o = src1;
  assign bus.Jump_R_o       = jump_r;
  assign bus.illegal_o      = unknown && bus.valid_i;
  assign bus.mul_start_o    = mul_start_q;
  assign bus.mul_op_o       = mul_op_q;
  assign bus.hilo_we_o      = hilo_we_q;
  assign bus.stall_o        = rst_i && (accept || ((state_q == StRun) && !bus.flush_i));

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed self-checking bench for alu_ctrl_mc (decode, MULT/DIVU sequencing, flush, reset).
module tb_alu_ctrl_mc;
  localparam int unsigned CW = 5;
  localparam int unsigned MC = 4;
  localparam int unsigned DC = 32;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_ctrl_mc_if #(.CTRL_WIDTH(CW)) bus ();

  alu_ctrl_mc #(
    .CTRL_WIDTH (CW),
    .MUL_CYCLES (MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic f, input logic [5:0] fn, input logic [3:0] op);
    bus.valid_i = v;
    bus.flush_i = f;
    bus.funct_i = fn;
    bus.ALUOp_i = op;
    #1;
  endtask

  // Full accept/RUN/DONE sequence; optional flush asserted in the DONE cycle.
  task automatic run_mul(input logic [5:0] fn, input int lat, input logic [1:0] op,
                         input logic flush_done);
    drive(1'b1, 1'b0, fn, 4'd0);
    chk("acc_stall", bus.stall_o, 1);
    chk("acc_start", bus.mul_start_o, 0);
    chk("acc_illegal", bus.illegal_o, 0);
    for (int c = 1; c <= lat; c++) begin
      tick();
      chk("run_stall", bus.stall_o, 1);
      chk("run_start", bus.mul_start_o, (c == 1) ? 1 : 0);
      chk("run_hilo", bus.hilo_we_o, 0);
      if (c == 1) chk("run_op", bus.mul_op_o, op);
    end
    tick();
    drive(1'b0, flush_done, 6'd0, 4'd0);
    chk("done_stall", bus.stall_o, 0);
    chk("done_hilo", bus.hilo_we_o, 1);
    tick();
    drive(1'b0, 1'b0, 6'd0, 4'd0);
    chk("idle_hilo", bus.hilo_we_o, 0);
    chk("idle_stall", bus.stall_o, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.funct_i = 6'd0;
    bus.ALUOp_i = 4'd0;
    #1 rst = 1'b0;
    #1;
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_start", bus.mul_start_o, 0);
    chk("rst_op", bus.mul_op_o, 0);
    chk("rst_hilo", bus.hilo_we_o, 0);
    tick();
    tick();
    #1 rst = 1'b1;
    tick();

    // R-type decode
    drive(1'b1, 1'b0, 6'b100001, 4'd0);
    chk("addu_ctrl", bus.ALUCtrl_o, 4);
    chk("addu_src1", bus.Mux_ALU_src1_o, 0);
    chk("addu_jr", bus.Jump_R_o, 0);
    chk("addu_sext", bus.Sign_extend_o, 0);
    chk("addu_stall", bus.stall_o, 0);
    drive(1'b1, 1'b0, 6'b000011, 4'd0);
    chk("sra_ctrl", bus.ALUCtrl_o, 8);
    chk("sra_src1", bus.Mux_ALU_src1_o, 1);
    chk("sra_jr", bus.Jump_R_o, 0);
    drive(1'b1, 1'b0, 6'b001000, 4'd0);
    chk("jr_ctrl", bus.ALUCtrl_o, 18);
    chk("jr_src1", bus.Mux_ALU_src1_o, 0);
    chk("jr_jr", bus.Jump_R_o, 1);
    drive(1'b1, 1'b0, 6'b000000, 4'd0);
    chk("sll_ctrl", bus.ALUCtrl_o, 12);
    chk("sll_src1", bus.Mux_ALU_src1_o, 1);
    drive(1'b1, 1'b0, 6'b000111, 4'd0);
    chk("srav_src1", bus.Mux_ALU_src1_o, 0);

    // I-type decode
    drive(1'b1, 1'b0, 6'd0, 4'd1);
    chk("addi_ctrl", bus.ALUCtrl_o, 4);
    chk("addi_sext", bus.Sign_extend_o, 1);
    chk("addi_stall", bus.stall_o, 0);
    drive(1'b1, 1'b0, 6'd0, 4'd4);
    chk("lui_ctrl", bus.ALUCtrl_o, 10);
    chk("lui_sext", bus.Sign_extend_o, 0);
    drive(1'b1, 1'b0, 6'd0, 4'd9);
    chk("blez_ctrl", bus.ALUCtrl_o, 7);
    chk("blez_sext", bus.Sign_extend_o, 1);
    drive(1'b1, 1'b0, 6'd0, 4'd2);
    chk("sltiu_sext", bus.Sign_extend_o, 0);

    // Illegal encodings
    drive(1'b1, 1'b0, 6'd0, 4'd14);
    chk("op14_illegal", bus.illegal_o, 1);
    chk("op14_ctrl", bus.ALUCtrl_o, 0);
    drive(1'b1, 1'b0, 6'b111111, 4'd0);
    chk("fn3f_illegal", bus.illegal_o, 1);
    chk("fn3f_ctrl", bus.ALUCtrl_o, 0);
    chk("fn3f_stall", bus.stall_o, 0);
    drive(1'b0, 1'b0, 6'd0, 4'd15);
    chk("op15_novalid", bus.illegal_o, 0);
    tick();

    // MULT, 4-cycle latency
    run_mul(6'b011000, MC, 2'd0, 1'b0);

    // DIVU
`ifdef ALU_CTRL_DIV_EN
    run_mul(6'b011011, DC, 2'd3, 1'b0);
`else
    drive(1'b1, 1'b0, 6'b011011, 4'd0);
    chk("divu_illegal", bus.illegal_o, 1);
    chk("divu_ctrl", bus.ALUCtrl_o, 0);
    chk("divu_stall", bus.stall_o, 0);
    tick();
    chk("divu_start", bus.mul_start_o, 0);
    chk("divu_stall2", bus.stall_o, 0);
    drive(1'b0, 1'b0, 6'd0, 4'd0);
    tick();
`endif

    // MULTU flushed in RUN cycle 2
    drive(1'b1, 1'b0, 6'b011001, 4'd0);
    chk("mu_acc_stall", bus.stall_o, 1);
    tick();
    chk("mu_start", bus.mul_start_o, 1);
    chk("mu_op", bus.mul_op_o, 1);
    tick();
    drive(1'b0, 1'b1, 6'd0, 4'd0);
    chk("mu_flush_stall", bus.stall_o, 0);
    tick();
    drive(1'b0, 1'b0, 6'd0, 4'd0);
    for (int c = 0; c < 6; c++) begin
      chk("mu_post_hilo", bus.hilo_we_o, 0);
      chk("mu_post_stall", bus.stall_o, 0);
      tick();
    end

    // Flush coincident with acceptance
    drive(1'b1, 1'b1, 6'b011000, 4'd0);
    chk("fa_stall", bus.stall_o, 0);
    tick();
    chk("fa_start", bus.mul_start_o, 0);
    drive(1'b0, 1'b0, 6'd0, 4'd0);
    chk("fa_stall2", bus.stall_o, 0);
    tick();

    // Reset asserted mid-RUN
    drive(1'b1, 1'b0, 6'b011001, 4'd0);
    tick();
    chk("mr_start", bus.mul_start_o, 1);
    rst = 1'b0;
    bus.ALUOp_i = 4'd4;
    #1;
    chk("mr_stall", bus.stall_o, 0);
    chk("mr_start0", bus.mul_start_o, 0);
    chk("mr_hilo", bus.hilo_we_o, 0);
    chk("mr_op", bus.mul_op_o, 0);
    chk("mr_decode", bus.ALUCtrl_o, 10);
    drive(1'b0, 1'b0, 6'd0, 4'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_stall", bus.stall_o, 0);

    // New MULT completes normally; flush in DONE keeps the commit
    run_mul(6'b011000, MC, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
Parametrised successor of the EX-stage ALU control decoder. It decodes funct_i and ALUOp_i into ALU control, sign-extend, src1-mux and jump-register signals, exactly as the single-cycle control does. It adds a multi-cycle sequencer for MULT/MULTU/DIV/DIVU: it starts the iterative mul/div unit, stalls the pipeline for a parametrised latency, and commits HI/LO. It sits between the ID/EX register and the ALU plus the mul/div unit.

Parameters:
CTRL_WIDTH, 5, width of ALUCtrl_o (>=5, to hold the new codes)
MUL_CYCLES, 4, cycles from mul_start_o to result ready (>=1)
DIV_CYCLES, 32, cycles from mul_start_o to divide result ready (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
valid_i  in  1  ID/EX holds a valid instruction
flush_i  in  1  EX flush (branch mispredict/exception)
funct_i  in  6  instruction funct field
ALUOp_i  in  4  decoder ALUOp
ALUCtrl_o  out  CTRL_WIDTH  ALU operation code
Sign_extend_o  out  1  immediate sign-extend select
Mux_ALU_src1_o  out  2  ALU src1 select (1 = shamt)
Jump_R_o  out  1  jump-register (R-type funct 001000)
illegal_o  out  1  unknown ALUOp/funct while valid_i
mul_start_o  out  1  one-cycle start pulse to mul/div unit
mul_op_o  out  2  latched op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
stall_o  out  1  hold IF/ID/EX
hilo_we_o  out  1  one-cycle HI/LO write enable

Behaviour:
- Decode is combinational and free of latches; every output gets a default each evaluation.
- Codes: AND0 OR1 LW2 SW3 ADDU4 SUBU5 SLT6 BLEZ7 SRA8 SRAV9 LUI10 SLTU11 SLL12 MULT13 BGTZ14 MULTU15 DIV16 DIVU17 JR18.
- ALUOp values: R0 ADDI1 SLTIU2 BEQ3 LUI4 ORI5 BNE6 LW7 SW8 BLEZ9 BGTZ10 JRS11 J12 JAL13.
- Sign_extend_o=1 for ADDI, BEQ, BNE, LW, SW, BLEZ, BGTZ, J, JAL. All other ALUOps drive 0.
- R-type funct map: 100001 ADDU; 100011 SUBU; 100100 AND; 100101 OR; 101010 SLT; 000011 SRA; 000111 SRAV; 000000 SLL; 001000 JR with Jump_R_o=1; 011000 MULT; 011001 MULTU; 011010 DIV; 011011 DIVU.
- Mux_ALU_src1_o=1 only for R-type SRA/SLL, otherwise 0.
- Unknown funct or ALUOp 14/15 with valid_i=1: ALUCtrl_o=AND and illegal_o=1. No start is issued.
- FSM states: IDLE, RUN, DONE. Counter width is clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- IDLE: valid_i=1, no flush_i, and a mul/div funct together constitute acceptance.
  - stall_o=1 combinationally in the acceptance cycle.
  - Next edge: mul_start_o=1 for that one cycle, mul_op_o latched, count=latency-1, go to RUN.
- RUN: stall_o=1 and mul_start_o=0. Count decrements each cycle; at 0, go to DONE.
- DONE: stall_o=0 (the mul/div instruction leaves EX), hilo_we_o=1 for exactly one cycle, then go to IDLE.
  - valid_i/funct_i are ignored in DONE.
- Total stall = latency+1 cycles; first new acceptance is possible in the cycle after DONE.
- flush_i in the acceptance cycle: flush wins, no start, stay IDLE.
- flush_i in RUN: go to IDLE next edge, no hilo_we_o, stall_o=0 in that flush cycle.
- flush_i in DONE: hilo_we_o is still asserted (the op is already committed).
- Reset (asynchronous, any state): state=IDLE, count=0, mul_start_o=0, mul_op_o=0, hilo_we_o=0. stall_o=0 while rst_i=0.
- Decode outputs follow their inputs even during reset.

Optional Feature:
ALU_CTRL_DIV_EN
- Defined: DIV/DIVU decode to codes 16/17 and run for DIV_CYCLES.
- Undefined: funct 011010/011011 are illegal (illegal_o=1, ALUCtrl_o=AND, no start, no stall), and the DIV_CYCLES counter path is not built.

Test Plan:
- ALUOp=0, funct=100001/000011/001000 -> ALUCtrl 4/8/18; Mux_ALU_src1 0/1/0; Jump_R 0/0/1; Sign_extend 0.
- ALUOp=1/4/9 -> ALUCtrl 4/10/7; Sign_extend 1/0/1; no stall.
- MULT with MUL_CYCLES=4 -> stall high 5 cycles, mul_start pulse at cycle 1, mul_op=0, hilo_we single pulse in the cycle stall drops.
- DIVU with DIV_CYCLES=32, macro on -> 33-cycle stall, mul_op=3. With macro off -> illegal_o=1 and no stall.
- MULTU, flush_i at RUN cycle 2 -> stall low that cycle, IDLE next, hilo_we never asserted. Flush coincident with acceptance -> no mul_start.
- rst_i low mid-RUN -> stall_o, mul_start_o, hilo_we_o all 0 immediately. After release, a new MULT completes normally.
